// File: rtl/pll_lock_sequencer.sv
// Turns the asynchronous PLL lock flag into a debounced, synchronous active-low
// reset for the PLL output clock domain, with lock-loss detection and a debug counter.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             locked_in,
    input  logic             clear_count,
    output logic             user_reset_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int PHASE_W    = $clog2(MAX_CYCLES) + 1;

    localparam logic [PHASE_W-1:0] STABLE_LAST = PHASE_W'(STABLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE   = PHASE_W'(1);
    localparam logic [CNT_W-1:0]   COUNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   COUNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   locked_sync;
    state_t                 cur_state;
    state_t                 next_state;
    logic [PHASE_W-1:0]     phase_cnt;
    logic [PHASE_W-1:0]     next_phase_cnt;
    logic                   loss_event;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign locked_sync = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur_state <= WAIT_LOCK;
            phase_cnt <= '0;
        end else begin
            cur_state <= next_state;
            phase_cnt <= next_phase_cnt;
        end
    end

    // Any low seen on the synchronised lock restarts the whole sequence; only a
    // drop while in RUN counts as a loss event.
    always_comb begin
        next_state     = cur_state;
        next_phase_cnt = phase_cnt;
        loss_event     = 1'b0;
        case (cur_state)
            WAIT_LOCK: begin
                next_phase_cnt = '0;
                if (locked_sync) begin
                    next_state = STABILISE;
                end
            end
            STABILISE: begin
                if (!locked_sync) begin
                    next_state     = WAIT_LOCK;
                    next_phase_cnt = '0;
                end else if (phase_cnt == STABLE_LAST) begin
                    next_state     = HOLD;
                    next_phase_cnt = '0;
                end else begin
                    next_phase_cnt = phase_cnt + PHASE_ONE;
                end
            end
            HOLD: begin
                if (!locked_sync) begin
                    next_state     = WAIT_LOCK;
                    next_phase_cnt = '0;
                end else if (phase_cnt == HOLD_LAST) begin
                    next_state     = RUN;
                    next_phase_cnt = '0;
                end else begin
                    next_phase_cnt = phase_cnt + PHASE_ONE;
                end
            end
            RUN: begin
                next_phase_cnt = '0;
                if (!locked_sync) begin
                    next_state = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                next_state     = WAIT_LOCK;
                next_phase_cnt = '0;
            end
        endcase
    end

    // A clear coinciding with a loss keeps that loss, so the count lands on one.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            lock_lost <= loss_event;
            if (clear_count) begin
                loss_count <= loss_event ? COUNT_ONE : '0;
            end else if (loss_event && (loss_count != COUNT_MAX)) begin
                loss_count <= loss_count + COUNT_ONE;
            end
        end
    end

    assign user_reset_n = (cur_state == RUN);
    assign ready        = (cur_state == RUN);
    assign state        = cur_state;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Consumes the asynchronous lock indication from the SB_PLL40 wrapper and produces a clean, synchronous, active-low reset for logic on the PLL output clock (clock_usb domain). Lock is synchronised, then debounced: it must stay stable for a programmable window, and reset is held for a further number of cycles before release. Loss of lock during run is detected, re-asserts reset, pulses an event and increments a saturating loss counter for debug.

Parameters:
SYNC_STAGES, 2, flops in the locked_in synchroniser (legal: >=2)
STABLE_CYCLES, 1024, consecutive cycles locked_sync must be 1 before hold phase (legal: >=1)
HOLD_CYCLES, 16, cycles user reset stays asserted after stable window (legal: >=1)
CNT_W, 8, width of loss_count

Ports:
clock  in  1  PLL output clock (clock_usb); all logic on rising edge
resetn  in  1  synchronous active-low reset
locked_in  in  1  PLL LOCK, asynchronous to clock, may glitch
clear_count  in  1  synchronous clear of loss_count
user_reset_n  out  1  active-low reset for downstream logic; 1 only in RUN
ready  out  1  1 only in RUN (same timing as user_reset_n)
lock_lost  out  1  one-cycle pulse on RUN -> WAIT_LOCK due to lock loss
loss_count  out  CNT_W  saturating count of lock-loss events
state  out  2  FSM state: 0 WAIT_LOCK, 1 STABILISE, 2 HOLD, 3 RUN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (resetn sampled on rising edge of clock).
- Reset (resetn=0 at an edge): state=WAIT_LOCK, synchroniser flops=0, phase counter=0, user_reset_n=0, ready=0, lock_lost=0, loss_count=0. Applies identically mid-operation, including in RUN; no lock_lost pulse or count increment from reset.
- Synchroniser: locked_sync = locked_in delayed through SYNC_STAGES flops. FSM acts on locked_sync only.
- Outputs user_reset_n, ready and state decode the registered state directly, with no extra pipeline. lock_lost and loss_count are registered.
- WAIT_LOCK: phase counter=0. If locked_sync=1, go to STABILISE.
- STABILISE: if locked_sync=0, go to WAIT_LOCK (no event, count unchanged). Otherwise increment the counter. When the counter reaches STABLE_CYCLES-1 with locked_sync=1, go to HOLD and set counter=0. STABILISE therefore lasts exactly STABLE_CYCLES cycles.
- HOLD: if locked_sync=0, go to WAIT_LOCK (no event). Otherwise count to HOLD_CYCLES-1, then go to RUN. HOLD lasts exactly HOLD_CYCLES cycles.
- RUN: if locked_sync=0, go to WAIT_LOCK, assert lock_lost for the next cycle only, and loss_count += 1 saturating at 2^CNT_W-1.
- Release latency: user_reset_n rises after exactly SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES+1 rising edges, counting the first edge that samples locked_in=1 (with locked_in held high throughout).
- Assert latency: user_reset_n falls after SYNC_STAGES+1 edges from the first edge sampling locked_in=0 in RUN.
- clear_count: loss_count=0 next cycle. If clear_count and a loss event occur in the same cycle, loss_count=1 and lock_lost still pulses.
- Phase counter width: clog2(max(STABLE_CYCLES,HOLD_CYCLES))+1. No wrap is possible because phase exit occurs at the terminal count.
- Glitch shorter than SYNC_STAGES cycles may or may not propagate. Any propagated low restarts sequencing from WAIT_LOCK.
- locked_in stuck at 0: remain in WAIT_LOCK indefinitely, user_reset_n=0.

Test Plan:
- Params 2/8/4, CNT_W=4. Reset, then locked_in=1 held: state 0->1->2->3; user_reset_n and ready rise on the 15th edge after locked_in is sampled high; lock_lost=0; loss_count=0.
- In RUN, drop locked_in for 10 cycles: user_reset_n=0 three edges after the drop; lock_lost high exactly 1 cycle; loss_count=1. Restore locked_in: RUN again 15 edges later.
- During STABILISE, pulse locked_in low for 4 cycles after 5 high cycles: return to WAIT_LOCK, no lock_lost, loss_count unchanged. The full 8+4 window restarts after relock.
- 17 RUN-loss events: loss_count saturates at 15. Assert clear_count: loss_count=0. Then clear_count coincident with a loss event: loss_count=1, lock_lost=1.
- resetn=0 for 1 cycle while in RUN with loss_count=5: next cycle state=0, user_reset_n=0, ready=0, loss_count=0, lock_lost=0.
- Hold locked_in=0 for 2000 cycles after reset: state stays 0, user_reset_n stays 0, no pulses.
